// File: rtl/psp_rvfi_gen.sv
// RVFI retirement packet generator: holds each commit in a one-entry slot until its successor PC is known.
// Optional duplicate-commit detection is built when PSP_RVFI_DUP_CHECK_EN is defined.
module psp_rvfi_gen #(
  parameter int TIMEOUT = 64,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [31:0]     commit_insn,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [4:0]      commit_rs1_addr,
  input  logic [4:0]      commit_rs2_addr,
  input  logic [XLEN-1:0] commit_rs1_rdata,
  input  logic [XLEN-1:0] commit_rs2_rdata,
  input  logic [4:0]      commit_rd_addr,
  input  logic [XLEN-1:0] commit_rd_wdata,
  input  logic [XLEN-1:0] commit_mem_addr,
  input  logic [3:0]      commit_mem_rmask,
  input  logic [3:0]      commit_mem_wmask,
  input  logic [XLEN-1:0] commit_mem_rdata,
  input  logic [XLEN-1:0] commit_mem_wdata,
  input  logic            drain,
  output logic            rvfi_valid,
  output logic [63:0]     rvfi_order,
  output logic [31:0]     rvfi_insn,
  output logic [XLEN-1:0] rvfi_pc_rdata,
  output logic [XLEN-1:0] rvfi_pc_wdata,
  output logic [4:0]      rvfi_rs1_addr,
  output logic [4:0]      rvfi_rs2_addr,
  output logic [XLEN-1:0] rvfi_rs1_rdata,
  output logic [XLEN-1:0] rvfi_rs2_rdata,
  output logic [4:0]      rvfi_rd_addr,
  output logic [XLEN-1:0] rvfi_rd_wdata,
  output logic [XLEN-1:0] rvfi_mem_addr,
  output logic [3:0]      rvfi_mem_rmask,
  output logic [3:0]      rvfi_mem_wmask,
  output logic [XLEN-1:0] rvfi_mem_rdata,
  output logic [XLEN-1:0] rvfi_mem_wdata,
  output logic            slot_full,
  output logic            dup_err
);

  typedef enum logic {EMPTY, HELD} state_t;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_rmask;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
  } slot_t;

  state_t          state, state_next;
  slot_t           slot, commit_rec;
  logic [63:0]     pkt_count;
  logic [31:0]     idle_cnt;
  logic            emit, capture, timeout_hit;
  logic [XLEN-1:0] pc_next;

  // x0 writes are architecturally invisible, so the trace reports zero.
  assign commit_rec = '{
    insn:      commit_insn,
    pc:        commit_pc,
    rs1_addr:  commit_rs1_addr,
    rs2_addr:  commit_rs2_addr,
    rs1_rdata: commit_rs1_rdata,
    rs2_rdata: commit_rs2_rdata,
    rd_addr:   commit_rd_addr,
    rd_wdata:  (commit_rd_addr == 5'd0) ? '0 : commit_rd_wdata,
    mem_addr:  commit_mem_addr,
    mem_rmask: commit_mem_rmask,
    mem_wmask: commit_mem_wmask,
    mem_rdata: commit_mem_rdata,
    mem_wdata: commit_mem_wdata
  };

  // The idle cycle that brings the counter to TIMEOUT is the one that flushes.
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == 32'(TIMEOUT - 1));
  assign slot_full   = (state == HELD);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    emit       = 1'b0;
    capture    = 1'b0;
    pc_next    = '0;
    case (state)
      EMPTY: begin
        if (commit_valid) begin
          capture    = 1'b1;
          state_next = HELD;
        end
      end
      HELD: begin
        if (commit_valid) begin
          emit    = 1'b1;
          capture = 1'b1;
          pc_next = commit_pc;
        end else if (drain || timeout_hit) begin
          emit       = 1'b1;
          pc_next    = slot.pc + XLEN'(4);
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: the slot payload has no reset; it is only observed while state is HELD.
  always_ff @(posedge clk) begin
    if (capture) slot <= commit_rec;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state          <= EMPTY;
      idle_cnt       <= '0;
      pkt_count      <= '0;
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      rvfi_insn      <= '0;
      rvfi_pc_rdata  <= '0;
      rvfi_pc_wdata  <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_mem_addr  <= '0;
      rvfi_mem_rmask <= '0;
      rvfi_mem_wmask <= '0;
      rvfi_mem_rdata <= '0;
      rvfi_mem_wdata <= '0;
    end else begin
      state      <= state_next;
      rvfi_valid <= emit;
      if (capture || state_next == EMPTY) idle_cnt <= '0;
      else if (TIMEOUT != 0)              idle_cnt <= idle_cnt + 32'd1;
      if (emit) begin
        rvfi_order     <= pkt_count;
        pkt_count      <= pkt_count + 64'd1;
        rvfi_insn      <= slot.insn;
        rvfi_pc_rdata  <= slot.pc;
        rvfi_pc_wdata  <= pc_next;
        rvfi_rs1_addr  <= slot.rs1_addr;
        rvfi_rs2_addr  <= slot.rs2_addr;
        rvfi_rs1_rdata <= slot.rs1_rdata;
        rvfi_rs2_rdata <= slot.rs2_rdata;
        rvfi_rd_addr   <= slot.rd_addr;
        rvfi_rd_wdata  <= slot.rd_wdata;
        rvfi_mem_addr  <= slot.mem_addr;
        rvfi_mem_rmask <= slot.mem_rmask;
        rvfi_mem_wmask <= slot.mem_wmask;
        rvfi_mem_rdata <= slot.mem_rdata;
        rvfi_mem_wdata <= slot.mem_wdata;
      end
    end
  end

`ifdef PSP_RVFI_DUP_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) dup_err <= 1'b0;
    else if (state == HELD && commit_valid &&
             commit_pc == slot.pc && commit_insn == slot.insn) dup_err <= 1'b1;
  end
`else
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_psp_rvfi_gen.sv
// Self-checking bench for psp_rvfi_gen: directed test-plan steps, then random traffic against a packet-level model.
module tb_psp_rvfi_gen;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_rmask;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
  } rec_t;

  typedef struct packed {
    logic [63:0]     order;
    logic [31:0]     insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_rmask;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
  } pkt_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic commit_valid = 1'b0;
  logic drain = 1'b0;
  rec_t cin = '0;

  logic            rvfi_valid, slot_full, dup_err;
  logic [63:0]     rvfi_order;
  logic [31:0]     rvfi_insn;
  logic [XLEN-1:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
  logic [XLEN-1:0] rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [4:0]      rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [3:0]      rvfi_mem_rmask, rvfi_mem_wmask;
  pkt_t            act;

  always #5 clk = ~clk;

  psp_rvfi_gen #(.TIMEOUT(TIMEOUT), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid),
    .commit_insn(cin.insn), .commit_pc(cin.pc),
    .commit_rs1_addr(cin.rs1_addr), .commit_rs2_addr(cin.rs2_addr),
    .commit_rs1_rdata(cin.rs1_rdata), .commit_rs2_rdata(cin.rs2_rdata),
    .commit_rd_addr(cin.rd_addr), .commit_rd_wdata(cin.rd_wdata),
    .commit_mem_addr(cin.mem_addr), .commit_mem_rmask(cin.mem_rmask),
    .commit_mem_wmask(cin.mem_wmask), .commit_mem_rdata(cin.mem_rdata),
    .commit_mem_wdata(cin.mem_wdata), .drain(drain),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .slot_full(slot_full), .dup_err(dup_err)
  );

  assign act = {rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr,
                rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_addr, rvfi_rd_wdata,
                rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata};

`ifdef PSP_RVFI_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the pending (not yet retired) instruction and the last packet seen on RVFI.
  bit          m_full;
  rec_t        m_pend;
  int          m_idle;
  logic [63:0] m_retired;
  bit          m_dup;
  bit          exp_valid;
  pkt_t        m_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pkt(input string tag, input pkt_t obs, input pkt_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic rec_t strip_x0(input rec_t r);
    rec_t t = r;
    if (t.rd_addr == 5'd0) t.rd_wdata = '0;
    return t;
  endfunction

  task automatic retire(input logic [XLEN-1:0] next_pc);
    m_last = '{order: m_retired, insn: m_pend.insn, pc_rdata: m_pend.pc, pc_wdata: next_pc,
               rs1_addr: m_pend.rs1_addr, rs2_addr: m_pend.rs2_addr,
               rs1_rdata: m_pend.rs1_rdata, rs2_rdata: m_pend.rs2_rdata,
               rd_addr: m_pend.rd_addr, rd_wdata: m_pend.rd_wdata,
               mem_addr: m_pend.mem_addr, mem_rmask: m_pend.mem_rmask,
               mem_wmask: m_pend.mem_wmask, mem_rdata: m_pend.mem_rdata,
               mem_wdata: m_pend.mem_wdata};
    m_retired = m_retired + 64'd1;
    exp_valid = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare at the falling edge.
  task automatic step(input bit cv, input rec_t r, input bit drn, input bit rst);
    commit_valid = cv;
    cin          = r;
    drain        = drn;
    reset        = rst;
    @(posedge clk);
    exp_valid = 1'b0;
    if (rst) begin
      m_full = 0; m_idle = 0; m_retired = '0; m_dup = 0; m_last = '0;
    end else if (m_full && cv) begin
      if (DUP_EN && r.pc == m_pend.pc && r.insn == m_pend.insn) m_dup = 1;
      retire(r.pc);
      m_pend = strip_x0(r);
      m_idle = 0;
    end else if (m_full && (drn || (TIMEOUT != 0 && m_idle + 1 == TIMEOUT))) begin
      retire(m_pend.pc + 32'd4);
      m_full = 0;
    end else if (m_full) begin
      m_idle++;
    end else if (cv) begin
      m_pend = strip_x0(r);
      m_full = 1;
      m_idle = 0;
    end
    @(negedge clk);
    check("rvfi_valid", 64'(rvfi_valid), 64'(exp_valid));
    check("slot_full", 64'(slot_full), 64'(m_full));
    check("dup_err", 64'(dup_err), 64'(m_dup));
    check_pkt("packet", act, m_last);
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.insn      = 32'h0000_0013 | ($urandom_range(0, 3) << 20);
    r.pc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 15)) << 2;
    r.rs1_addr  = 5'($urandom);
    r.rs2_addr  = 5'($urandom);
    r.rs1_rdata = $urandom;
    r.rs2_rdata = $urandom;
    r.rd_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    r.rd_wdata  = $urandom;
    r.mem_addr  = $urandom;
    r.mem_rmask = 4'($urandom);
    r.mem_wmask = 4'($urandom);
    r.mem_rdata = $urandom;
    r.mem_wdata = $urandom;
    return r;
  endfunction

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] insn,
                              input logic [4:0] rd, input logic [31:0] wd);
    rec_t r = rand_rec();
    r.pc = pc; r.insn = insn; r.rd_addr = rd; r.rd_wdata = wd;
    return r;
  endfunction

  initial begin
    rec_t idle_r = '0;
    rec_t r;
    m_full = 0; m_idle = 0; m_retired = '0; m_dup = 0; m_last = '0; exp_valid = 0;
    @(negedge clk);

    // Reset state
    step(0, idle_r, 0, 1);
    step(0, idle_r, 0, 1);
    check("reset_order", rvfi_order, 64'd0);

    // Single addi then drain
    step(1, mk(32'h0, 32'h0010_0093, 5'd1, 32'd1), 0, 0);
    step(0, idle_r, 1, 0);
    check("t1_valid", 64'(rvfi_valid), 64'd1);
    check("t1_order", rvfi_order, 64'd0);
    check("t1_pc_wdata", 64'(rvfi_pc_wdata), 64'h4);
    check("t1_rd_wdata", 64'(rvfi_rd_wdata), 64'd1);
    check("t1_slot_full", 64'(slot_full), 64'd0);

    // Back-to-back commits then drain; drain while empty does nothing
    step(0, idle_r, 1, 0);
    step(1, mk(32'h0, 32'h0010_0093, 5'd1, 32'd1), 0, 0);
    step(1, mk(32'h4, 32'h0020_0113, 5'd2, 32'd2), 0, 0);
    check("t2_pc_wdata0", 64'(rvfi_pc_wdata), 64'h4);
    step(1, mk(32'h100, 32'h0030_0193, 5'd3, 32'd3), 1, 0);
    check("t2_pc_wdata1", 64'(rvfi_pc_wdata), 64'h100);
    step(0, idle_r, 1, 0);
    check("t2_pc_wdata2", 64'(rvfi_pc_wdata), 64'h104);
    check("t2_order2", rvfi_order, 64'd3);

    // Write to x0 is reported as zero
    step(1, mk(32'h200, 32'h1234_5013, 5'd0, 32'hDEAD_BEEF), 0, 0);
    step(0, idle_r, 1, 0);
    check("t3_rd_wdata", 64'(rvfi_rd_wdata), 64'd0);

    // Timeout after four idle held cycles, with wrap of pc+4 checked by the random phase
    step(1, mk(32'h20, 32'h0000_0013, 5'd5, 32'd7), 0, 0);
    for (int i = 0; i < 3; i++) step(0, idle_r, 0, 0);
    check("t4_not_yet", 64'(rvfi_valid), 64'd0);
    step(0, idle_r, 0, 0);
    check("t4_fire", 64'(rvfi_valid), 64'd1);
    check("t4_pc_wdata", 64'(rvfi_pc_wdata), 64'h24);

    // Reset discards the held slot and restarts ordering
    step(1, mk(32'h40, 32'h0000_0013, 5'd1, 32'd1), 0, 0);
    step(0, idle_r, 0, 1);
    check("t5_no_emit", 64'(rvfi_valid), 64'd0);
    step(1, mk(32'h80, 32'h0000_0013, 5'd1, 32'd1), 0, 0);
    step(0, idle_r, 1, 0);
    check("t5_order", rvfi_order, 64'd0);

    // Duplicate commit
    r = mk(32'h8, 32'h0010_0093, 5'd1, 32'd1);
    step(1, r, 0, 0);
    step(1, r, 0, 0);
    step(0, idle_r, 1, 0);
    check("t6_dup_err", 64'(dup_err), 64'(DUP_EN));
    step(0, idle_r, 0, 0);
    check("t6_dup_sticky", 64'(dup_err), 64'(DUP_EN));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, rand_rec(), $urandom_range(0, 9) < 2,
           $urandom_range(0, 99) < 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
